dfp_frame_rx: RTL and testbench



---
 rtl/dfp_frame_rx.sv | 277 +++++++++++++++++++++++++++
 tb/tb_dfp_frame_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dfp_frame_rx.sv
// DFPlayer response receiver: 8N1 UART deserialiser plus 10-byte frame parser.
// Optional checksum verification is enabled with `define DFP_RX_CHECKSUM_EN.
module dfp_frame_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  output logic        frame_valid,
  output logic [7:0]  cmd,
  output logic        feedback,
  output logic [15:0] param,
  output logic        chk_err,
  output logic        frm_err,
  output logic        proto_err,
  output logic        rx_busy
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int TW  = $clog2(TIMEOUT_CLKS + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TIMEOUT_CLKS - 1);

  localparam logic [7:0] SOF = 8'h7E;
  localparam logic [7:0] VER = 8'hFF;
  localparam logic [7:0] LEN = 8'h06;
  localparam logic [7:0] EOF = 8'hEF;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } ustate_t;

  typedef enum logic [3:0] {
    P_WAIT,
    P_VER,
    P_LEN,
    P_CMD,
    P_FB,
    P_PH,
    P_PL,
    P_CKH,
    P_CKL,
    P_END
  } pstate_t;

  logic          rx_m;
  logic          rxs;
  ustate_t       ust;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          armed;
  logic          stb_pend;
  logic          byte_stb;

  pstate_t       pst;
  logic [TW-1:0] to_cnt;
  logic [7:0]    sh_cmd;
  logic          sh_fb;
  logic [7:0]    sh_ph;
  logic [7:0]    sh_pl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rxs  <= 1'b1;
    end else begin
      rx_m <= rx;
      rxs  <= rx_m;
    end
  end

  // armed drops after a framing error so a stuck-low line is not a start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ust      <= U_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      armed    <= 1'b1;
      stb_pend <= 1'b0;
      byte_stb <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      stb_pend <= 1'b0;
      byte_stb <= stb_pend;
      frm_err  <= 1'b0;
      unique case (ust)
        U_IDLE: begin
          cnt <= '0;
          if (rxs) begin
            armed <= 1'b1;
          end else if (armed) begin
            ust <= U_START;
          end
        end
        U_START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            ust     <= rxs ? U_IDLE : U_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        U_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              ust <= U_STOP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        U_STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            ust <= U_IDLE;
            if (rxs) begin
              stb_pend <= 1'b1;
            end else begin
              frm_err <= 1'b1;
              armed   <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ust <= U_IDLE;
      endcase
    end
  end

`ifdef DFP_RX_CHECKSUM_EN
  logic [15:0] sum;
  logic [7:0]  ckh;
  logic [7:0]  ckl;
  logic        ck_ok;
  logic        chk_r;

  // VER is always the first summed byte, so it restarts the accumulator
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum <= '0;
      ckh <= '0;
      ckl <= '0;
    end else if (byte_stb) begin
      unique case (pst)
        P_VER:                   sum <= {8'h00, shreg};
        P_LEN, P_CMD, P_FB,
        P_PH, P_PL:              sum <= sum + {8'h00, shreg};
        P_CKH:                   ckh <= shreg;
        P_CKL:                   ckl <= shreg;
        default: ;
      endcase
    end
  end

  assign ck_ok   = ({ckh, ckl} == 16'(16'd0 - sum));
  assign chk_err = chk_r;
`else
  assign chk_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pst         <= P_WAIT;
      to_cnt      <= '0;
      sh_cmd      <= '0;
      sh_fb       <= 1'b0;
      sh_ph       <= '0;
      sh_pl       <= '0;
      frame_valid <= 1'b0;
      proto_err   <= 1'b0;
      cmd         <= '0;
      feedback    <= 1'b0;
      param       <= '0;
`ifdef DFP_RX_CHECKSUM_EN
      chk_r       <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      proto_err   <= 1'b0;
`ifdef DFP_RX_CHECKSUM_EN
      chk_r       <= 1'b0;
`endif
      if (byte_stb) begin
        to_cnt <= '0;
        unique case (pst)
          P_WAIT: if (shreg == SOF) pst <= P_VER;
          P_VER: begin
            if (shreg == VER) begin
              pst <= P_LEN;
            end else begin
              proto_err <= 1'b1;
              pst       <= (shreg == SOF) ? P_VER : P_WAIT;
            end
          end
          P_LEN: begin
            if (shreg == LEN) begin
              pst <= P_CMD;
            end else begin
              proto_err <= 1'b1;
              pst       <= (shreg == SOF) ? P_VER : P_WAIT;
            end
          end
          P_CMD: begin
            sh_cmd <= shreg;
            pst    <= P_FB;
          end
          P_FB: begin
            sh_fb <= |shreg;
            pst   <= P_PH;
          end
          P_PH: begin
            sh_ph <= shreg;
            pst   <= P_PL;
          end
          P_PL: begin
            sh_pl <= shreg;
            pst   <= P_CKH;
          end
          P_CKH: pst <= P_CKL;
          P_CKL: pst <= P_END;
          P_END: begin
            if (shreg == EOF) begin
              pst <= P_WAIT;
`ifdef DFP_RX_CHECKSUM_EN
              if (ck_ok) begin
                frame_valid <= 1'b1;
                cmd         <= sh_cmd;
                feedback    <= sh_fb;
                param       <= {sh_ph, sh_pl};
              end else begin
                chk_r <= 1'b1;
              end
`else
              frame_valid <= 1'b1;
              cmd         <= sh_cmd;
              feedback    <= sh_fb;
              param       <= {sh_ph, sh_pl};
`endif
            end else begin
              proto_err <= 1'b1;
              pst       <= (shreg == SOF) ? P_VER : P_WAIT;
            end
          end
          default: pst <= P_WAIT;
        endcase
      end else if (pst != P_WAIT) begin
        if (to_cnt == TO_M1) begin
          proto_err <= 1'b1;
          pst       <= P_WAIT;
          to_cnt    <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign rx_busy = (pst != P_WAIT);

endmodule

// File: tb/tb_dfp_frame_rx.sv
// Scoreboard bench for dfp_frame_rx: directed DFPlayer frames plus random
// traffic, checked against a byte-buffer model of the frame format.
module tb_dfp_frame_rx;

  localparam int DIV = 10;
  localparam int TO  = 400;

  localparam int K_VALID = 0;
  localparam int K_CHK   = 1;
  localparam int K_FRM   = 2;
  localparam int K_PROTO = 3;

  typedef struct {
    int          kind;
    logic [7:0]  cmd;
    logic        fb;
    logic [15:0] param;
  } ev_t;

  logic        clk;
  logic        reset_n;
  logic        rx;
  logic        frame_valid;
  logic [7:0]  cmd;
  logic        feedback;
  logic [15:0] param;
  logic        chk_err;
  logic        frm_err;
  logic        proto_err;
  logic        rx_busy;

  int checks = 0;
  int errors = 0;

  ev_t        expq[$];
  logic [7:0] mbuf[$];
  logic [7:0] g_cmd;
  logic       g_fb;
  logic [15:0] g_param;

  dfp_frame_rx #(
    .CLK_HZ(1_000_000),
    .BAUD(100_000),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx(rx),
    .frame_valid(frame_valid),
    .cmd(cmd),
    .feedback(feedback),
    .param(param),
    .chk_err(chk_err),
    .frm_err(frm_err),
    .proto_err(proto_err),
    .rx_busy(rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_ev(input int k);
    ev_t e;
    e.kind  = k;
    e.cmd   = g_cmd;
    e.fb    = g_fb;
    e.param = g_param;
    expq.push_back(e);
  endtask

  // Frame model: position in the buffer decides what a byte must be.
  task automatic model_byte(input logic [7:0] b);
    int n;
    logic [15:0] s;
    logic ok;
    n = mbuf.size();
    if (n == 0) begin
      if (b == 8'h7E) mbuf.push_back(b);
    end else if ((n == 1 && b != 8'hFF) || (n == 2 && b != 8'h06) ||
                 (n == 9 && b != 8'hEF)) begin
      push_ev(K_PROTO);
      mbuf.delete();
      if (b == 8'h7E) mbuf.push_back(b);
    end else begin
      mbuf.push_back(b);
      if (mbuf.size() == 10) begin
        s = 16'h0;
        for (int i = 1; i <= 6; i++) s = s + {8'h00, mbuf[i]};
        ok = (({mbuf[7], mbuf[8]} + s) == 16'h0000);
`ifndef DFP_RX_CHECKSUM_EN
        ok = 1'b1;
`endif
        if (ok) begin
          g_cmd   = mbuf[3];
          g_fb    = (mbuf[4] != 8'h00);
          g_param = {mbuf[5], mbuf[6]};
          push_ev(K_VALID);
        end else begin
          push_ev(K_CHK);
        end
        mbuf.delete();
      end
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    model_byte(b);
    send_bits(b, 1'b1);
  endtask

  task automatic send_frame(input logic [79:0] f, input int maxgap);
    for (int i = 0; i < 10; i++) begin
      send_byte(f[79-8*i -: 8]);
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
    end
  endtask

  task automatic idle_chk_busy(input string nm);
    repeat (6) @(negedge clk);
    chk(nm, {31'd0, rx_busy}, {31'd0, (mbuf.size() != 0)});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, {31'd0, frame_valid}, 0);
    chk({nm, "_cmd"}, {24'd0, cmd}, 0);
    chk({nm, "_fb"}, {31'd0, feedback}, 0);
    chk({nm, "_param"}, {16'd0, param}, 0);
    chk({nm, "_errs"}, {29'd0, chk_err, frm_err, proto_err}, 0);
    chk({nm, "_busy"}, {31'd0, rx_busy}, 0);
  endtask

  task automatic mon_ev(input int k);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse: got kind %0d expected none", k);
    end else begin
      e = expq.pop_front();
      chk("ev_kind", k, e.kind);
      if (k == K_VALID) begin
        chk("valid_cmd", {24'd0, cmd}, {24'd0, e.cmd});
        chk("valid_fb", {31'd0, feedback}, {31'd0, e.fb});
        chk("valid_param", {16'd0, param}, {16'd0, e.param});
      end
      if (k == K_CHK) begin
        chk("hold_cmd", {24'd0, cmd}, {24'd0, e.cmd});
        chk("hold_param", {16'd0, param}, {16'd0, e.param});
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_valid) mon_ev(K_VALID);
      if (chk_err) mon_ev(K_CHK);
      if (frm_err) mon_ev(K_FRM);
      if (proto_err) mon_ev(K_PROTO);
    end
  end

  initial begin
    logic [7:0]  c;
    logic [7:0]  fb;
    logic [7:0]  ph;
    logic [7:0]  pl;
    logic [15:0] ck;
    g_cmd   = '0;
    g_fb    = 1'b0;
    g_param = '0;
    rx      = 1'b1;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    chk_zero("reset");
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    send_frame(80'h7EFF063F000002FEBAEF, 0);
    idle_chk_busy("busy_after_good");

    send_frame(80'h7EFF063D000001FEBCEF, 0);
    idle_chk_busy("busy_after_badck");

    send_byte(8'h7E);
    send_frame(80'h7EFF063D000001FEBDEF, 0);
    idle_chk_busy("busy_after_resync");

    push_ev(K_FRM);
    send_bits(8'h55, 1'b0);
    repeat (2 * DIV) @(negedge clk);
    send_frame(80'h7EFF0601000110FEE9EF, 0);
    idle_chk_busy("busy_after_frm");

    send_byte(8'h7E);
    send_byte(8'hFF);
    send_byte(8'h06);
    chk("busy_mid_frame", {31'd0, rx_busy}, 1);
    if (mbuf.size() != 0) push_ev(K_PROTO);
    mbuf.delete();
    repeat (TO + 60) @(negedge clk);
    chk("busy_after_timeout", {31'd0, rx_busy}, 0);

    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    chk("busy_after_glitch", {31'd0, rx_busy}, 0);

    for (int i = 0; i < 5; i++) send_byte(8'(80'h7EFF063F00 >> (32 - 8*i)));
    rx = 1'b0;
    repeat (35) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk_zero("reset_mid");
    mbuf.delete();
    g_cmd   = '0;
    g_fb    = 1'b0;
    g_param = '0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(80'h7EFF063F000002FEBAEF, 0);
    idle_chk_busy("busy_after_reset");

    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(0, 2)) send_byte(8'($urandom));
      c  = 8'($urandom);
      fb = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                       : 8'($urandom_range(0, 1));
      ph = 8'($urandom);
      pl = 8'($urandom);
      ck = 16'h0 - (16'h00FF + 16'h0006 + {8'h0, c} + {8'h0, fb} +
                    {8'h0, ph} + {8'h0, pl});
      if ($urandom_range(0, 3) == 0) ck = ck ^ 16'(1 << $urandom_range(0, 15));
      send_frame({8'h7E, 8'hFF, 8'h06, c, fb, ph, pl, ck, 8'hEF}, 40);
      idle_chk_busy("busy_random");
    end

    for (int i = 0; i < 300 && expq.size() != 0; i++) @(negedge clk);
    chk("drain_pending", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
